// File: rtl/dsp_sample_loader_pkg.sv
// Shared definitions for the Data Memory Bank I sample loader: widths, defaults and half-buffer states.
package dsp_sample_loader_pkg;

  localparam int unsigned REG_WORD_LEN     = 16;
  localparam int unsigned SRAM_ADDR_LEN    = 10;
  localparam int unsigned LOADER_FRAME_LEN = 256;
  localparam int unsigned LOADER_BASE_ADDR = 0;
  localparam int unsigned DROP_CNT_W       = 16;

  typedef enum logic {
    HALF_EMPTY = 1'b0,
    HALF_FULL  = 1'b1
  } half_state_t;

endpackage

// File: rtl/dsp_pingpong_status.sv
// Ping-pong bookkeeping: per-half resident flags, the half being filled and the half shown to the DSP.
module dsp_pingpong_status
  import dsp_sample_loader_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic fill_done,
  input  logic ack,
  output logic wr_blocked,
  output logic frame_rdy,
  output logic wr_half,
  output logic rd_half
);

  half_state_t half_state [2];
  logic        ack_take;

  assign wr_blocked = (half_state[wr_half] == HALF_FULL);
  // frame_rdy lags the flags by a cycle, so an ack in the cycle right after a release must not free a second half
  assign ack_take   = ack && frame_rdy && (half_state[rd_half] == HALF_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      half_state[0] <= HALF_EMPTY;
      half_state[1] <= HALF_EMPTY;
      wr_half       <= 1'b0;
      rd_half       <= 1'b0;
      frame_rdy     <= 1'b0;
    end else begin
      frame_rdy <= (half_state[rd_half] == HALF_FULL);
      // fill_done needs an empty wr_half and ack_take a full rd_half, so they never target the same half
      if (fill_done) begin
        half_state[wr_half] <= HALF_FULL;
        wr_half             <= !wr_half;
      end
      if (ack_take) begin
        half_state[rd_half] <= HALF_EMPTY;
        rd_half             <= !rd_half;
      end
    end
  end

endmodule

// File: rtl/dsp_sample_loader.sv
// Streams receiver samples into two ping-pong frame buffers in SRAM bank I and flags resident frames.
// Optional SAMPLE_DROP_CNT_EN: never back-pressure; discard samples while blocked and count them in drop_cnt.
module dsp_sample_loader
  import dsp_sample_loader_pkg::*;
#(
  parameter int unsigned DATA_W    = REG_WORD_LEN,
  parameter int unsigned ADDR_W    = SRAM_ADDR_LEN,
  parameter int unsigned FRAME_LEN = LOADER_FRAME_LEN,
  parameter int unsigned BASE_ADDR = LOADER_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [ADDR_W-1:0] write_addr_1,
  output logic [DATA_W-1:0] write_data_1,
  output logic              write_en_1,
  output logic              frame_rdy,
  output logic [ADDR_W-1:0] frame_base,
  input  logic              frame_ack
`ifdef SAMPLE_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam int unsigned       CNT_W = $clog2(FRAME_LEN);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] wr_cnt;
  logic             wr_half;
  logic             rd_half;
  logic             wr_blocked;
  logic             accept;
  logic             fill_done;

  dsp_pingpong_status u_status (
    .clk        (clk),
    .rst        (rst),
    .fill_done  (fill_done),
    .ack        (frame_ack),
    .wr_blocked (wr_blocked),
    .frame_rdy  (frame_rdy),
    .wr_half    (wr_half),
    .rd_half    (rd_half)
  );

`ifdef SAMPLE_DROP_CNT_EN
  assign sample_ready = 1'b1;
`else
  assign sample_ready = !wr_blocked;
`endif

  assign accept    = sample_valid && !wr_blocked;
  assign fill_done = accept && (wr_cnt == LAST);
  // FRAME_LEN is a power of two, so {half, offset} equals half*FRAME_LEN + offset
  assign frame_base = BASE + ADDR_W'({rd_half, {CNT_W{1'b0}}});

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt       <= '0;
      write_en_1   <= 1'b0;
      write_addr_1 <= '0;
      write_data_1 <= '0;
    end else begin
      write_en_1 <= accept;
      if (accept) begin
        write_addr_1 <= BASE + ADDR_W'({wr_half, wr_cnt});
        write_data_1 <= sample_in;
        wr_cnt       <= wr_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SAMPLE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (sample_valid && wr_blocked && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dsp_sample_loader.sv
// Self-checking bench for dsp_sample_loader: directed scenarios plus a randomized run against a frame-count model.
module tb_dsp_sample_loader;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 10;
  localparam int unsigned FL   = 4;
  localparam int unsigned BASE = 0;
`ifdef SAMPLE_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif
  localparam logic STALL_READY = DROP_EN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          frame_ack = 1'b0;
  logic          sample_ready;
  logic [AW-1:0] write_addr_1;
  logic [DW-1:0] write_data_1;
  logic          write_en_1;
  logic          frame_rdy;
  logic [AW-1:0] frame_base;
`ifdef SAMPLE_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dsp_sample_loader #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .FRAME_LEN (FL),
    .BASE_ADDR (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .write_addr_1 (write_addr_1),
    .write_data_1 (write_data_1),
    .write_en_1   (write_en_1),
    .frame_rdy    (frame_rdy),
    .frame_base   (frame_base),
    .frame_ack    (frame_ack)
`ifdef SAMPLE_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frames completed and frames released since reset; their difference is the number of resident halves.
  int            done = 0;
  int            rel  = 0;
  int            pos  = 0;
  bit            started = 1'b0;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_frdy = 1'b0;
  int            exp_drop = 0;

  always @(posedge clk) begin : model
    int cnt;
    bit blocked;
    bit acc;
    bit ackt;
    cnt     = done - rel;
    blocked = (cnt == 2);
    if (rst) begin
      done = 0; rel = 0; pos = 0;
      exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_frdy = 1'b0; exp_drop = 0;
      started = 1'b1;
    end else begin
      acc      = sample_valid && !blocked;
      ackt     = frame_ack && exp_frdy && (cnt > 0);
      exp_frdy = (cnt > 0);
      exp_we   = acc;
      if (acc) begin
        exp_addr = AW'(BASE + (done % 2) * FL + pos);
        exp_data = sample_in;
        pos++;
        if (pos == FL) begin
          pos = 0;
          done++;
        end
      end
      if (DROP_EN && sample_valid && blocked && exp_drop < 65535) exp_drop++;
      if (ackt) rel++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("sample_ready", 32'(sample_ready), DROP_EN ? 32'd1 : 32'((done - rel) != 2));
      check("write_en_1",   32'(write_en_1),   32'(exp_we));
      check("write_addr_1", 32'(write_addr_1), 32'(exp_addr));
      check("write_data_1", 32'(write_data_1), 32'(exp_data));
      check("frame_rdy",    32'(frame_rdy),    32'(exp_frdy));
      check("frame_base",   32'(frame_base),   32'(BASE + (rel % 2) * FL));
`ifdef SAMPLE_DROP_CNT_EN
      check("drop_cnt",     32'(drop_cnt),     32'(exp_drop));
`endif
    end
  end

  task automatic tick(input bit r, input bit v, input logic [DW-1:0] d, input bit a);
    rst          = r;
    sample_valid = v;
    sample_in    = d;
    frame_ack    = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tick(1, 0, '0, 0);
    tick(1, 0, '0, 0);
    tick(0, 0, '0, 0);
    check("rst_we",    32'(write_en_1),   32'd0);
    check("rst_addr",  32'(write_addr_1), 32'd0);
    check("rst_data",  32'(write_data_1), 32'd0);
    check("rst_frdy",  32'(frame_rdy),    32'd0);
    check("rst_base",  32'(frame_base),   32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);

    // first frame into half 0
    for (int i = 1; i <= 4; i++) begin
      tick(0, 1, DW'(i), 0);
      check("f0_we",   32'(write_en_1),   32'd1);
      check("f0_addr", 32'(write_addr_1), 32'(i - 1));
      check("f0_data", 32'(write_data_1), 32'(i));
    end
    check("f0_frdy_n1", 32'(frame_rdy), 32'd0);
    tick(0, 0, '0, 0);
    check("f0_frdy_n2", 32'(frame_rdy),  32'd1);
    check("f0_base",    32'(frame_base), 32'd0);

    // second frame into half 1, then stall
    for (int i = 5; i <= 8; i++) begin
      tick(0, 1, DW'(i), 0);
      check("f1_addr", 32'(write_addr_1), 32'(i - 1));
    end
    check("stall_ready", 32'(sample_ready), 32'(STALL_READY));
    for (int k = 0; k < 2; k++) begin
      tick(0, 1, DW'(9), 0);
      check("stall_we", 32'(write_en_1), 32'd0);
    end

    // ack with both halves full
    tick(0, 1, DW'(9), 1);
    check("ack_base",  32'(frame_base),   32'd4);
    check("ack_frdy",  32'(frame_rdy),    32'd1);
    check("ack_ready", 32'(sample_ready), 32'd1);
    check("ack_we",    32'(write_en_1),   32'd0);
    tick(0, 1, DW'(9), 0);
    check("refill_addr", 32'(write_addr_1), 32'd0);
    check("refill_data", 32'(write_data_1), 32'd9);

    // ack of half 1 in the cycle that writes the last word of half 0
    tick(0, 1, DW'(10), 0);
    tick(0, 1, DW'(11), 0);
    tick(0, 1, DW'(12), 0);
    check("last_addr", 32'(write_addr_1), 32'd3);
    tick(0, 0, '0, 1);
    check("sim_base", 32'(frame_base), 32'd0);
    check("sim_frdy", 32'(frame_rdy),  32'd1);
    tick(0, 0, '0, 0);
    check("sim_frdy2", 32'(frame_rdy), 32'd1);
    tick(0, 0, '0, 1);
    check("rel_base", 32'(frame_base), 32'd4);
    tick(0, 0, '0, 0);
    check("rel_frdy", 32'(frame_rdy), 32'd0);

    // spurious ack, then reset mid-frame
    tick(0, 0, '0, 1);
    check("spur_base", 32'(frame_base), 32'd4);
    check("spur_frdy", 32'(frame_rdy),  32'd0);
    tick(0, 1, DW'(13), 0);
    tick(0, 1, DW'(14), 0);
    check("mid_addr", 32'(write_addr_1), 32'd5);
    tick(1, 0, '0, 0);
    check("mid_rst_base", 32'(frame_base), 32'd0);
    tick(0, 1, DW'(15), 0);
    check("post_rst_addr", 32'(write_addr_1), 32'(BASE));
    check("post_rst_data", 32'(write_data_1), 32'd15);

`ifdef SAMPLE_DROP_CNT_EN
    tick(1, 0, '0, 0);
    for (int i = 1; i <= 8; i++) tick(0, 1, DW'(i), 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, DW'(16'h55), 0);
      check("drop_we",    32'(write_en_1),   32'd0);
      check("drop_ready", 32'(sample_ready), 32'd1);
    end
    check("drop_cnt3", 32'(drop_cnt), 32'd3);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick(($urandom_range(0, 255) == 0),
           ($urandom_range(0, 9) < 7),
           DW'($urandom),
           ($urandom_range(0, 4) == 0));
    end
    tick(0, 0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
